muldiv_seq: RTL and testbench

- Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage. Generalised successor to the single-cycle combinational mul/div path.
- Radix-2^MUL_UNROLL shift-add multiplier and a 1-bit-per-cycle restoring divider, sharing one datapath.
- The CPU hazard unit holds the pipeline while busy=1 and flushes an in-flight operation with kill.
- Handles RISC-V divide-by-zero and signed overflow in one cycle.

---
 rtl/muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// muldiv_seq - multi-cycle RV32M/RV64M multiply/divide unit (shift-add mul,
//              restoring div); MULDIV_RESULT_CACHE_EN adds a 1-entry cache.
// Revision 1.0
// ============================================================================
module muldiv_seq #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd
);

    localparam int c_W2    = 2 * XLEN;
    localparam int c_N_MUL = XLEN / MUL_UNROLL;
    localparam int c_CW    = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [c_W2-1:0] acc_q;
    logic [c_W2-1:0] mcand_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] rd_q;
    logic [c_CW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            div_q;
    logic            sel_hi_q;
    logic            neg_q;
    logic            rneg_q;

    logic            w_is_mul;
    logic            w_is_div;
    logic            w_valid;
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic            w_sel_hi;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div0;
    logic            w_ovf;
    logic            w_mul0;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;

    // MUL shares the signed x signed key with MULH so the cache can serve either
    always_comb begin
        w_is_mul  = (op[4:2] == 3'b100);
        w_is_div  = (op[4:2] == 3'b101);
        w_valid   = w_is_mul | w_is_div;
        w_a_sgn   = w_is_mul ? (op[1:0] != 2'b11) : ~op[0];
        w_b_sgn   = w_is_mul ? ~op[1] : ~op[0];
        w_sel_hi  = w_is_mul ? (op[1:0] != 2'b00) : op[1];
        w_a_neg   = w_a_sgn & rs1[XLEN-1];
        w_b_neg   = w_b_sgn & rs2[XLEN-1];
        w_a_abs   = w_a_neg ? -rs1 : rs1;
        w_b_abs   = w_b_neg ? -rs2 : rs2;
        w_div0    = w_is_div && (rs2 == '0);
        w_ovf     = w_is_div && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        w_mul0    = w_is_mul && ((rs1 == '0) || (rs2 == '0));
        w_special = w_div0 | w_ovf | w_mul0;
        if (w_div0) begin
            w_spec_res = op[1] ? rs1 : '1;
        end else if (w_ovf) begin
            w_spec_res = op[1] ? '0 : rs1;
        end else begin
            w_spec_res = '0;
        end
    end

    logic [c_W2-1:0] w_pp;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_trial;
    logic [c_W2-1:0] w_div_step;
    logic [c_W2-1:0] w_prod;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [c_W2-1:0] w_fix;
    logic [XLEN-1:0] w_fix_rd;
    logic [c_CW-1:0] w_last;

    // Divider packs {remainder, dividend/quotient} into the shared accumulator
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_UNROLL; j++) begin
            if (b_q[j]) begin
                w_pp = w_pp + (mcand_q << j);
            end
        end
        w_rem_sh   = {acc_q[c_W2-1:XLEN], acc_q[XLEN-1]};
        w_trial    = w_rem_sh - {1'b0, b_q};
        w_div_step = w_trial[XLEN] ? {w_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {w_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        w_prod     = neg_q ? -acc_q : acc_q;
        w_quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        w_rem      = rneg_q ? -acc_q[c_W2-1:XLEN] : acc_q[c_W2-1:XLEN];
        w_fix      = div_q ? {w_rem, w_quo} : w_prod;
        w_fix_rd   = sel_hi_q ? w_fix[c_W2-1:XLEN] : w_fix[XLEN-1:0];
        w_last     = div_q ? c_CW'(XLEN - 1) : c_CW'(c_N_MUL - 1);
    end

    logic            w_hit;
    logic [c_W2-1:0] w_cache_res;
    logic [XLEN-1:0] w_cache_rd;

`ifdef MULDIV_RESULT_CACHE_EN
    logic            key_div_q;
    logic [1:0]      key_sgn_q;
    logic [XLEN-1:0] key_rs1_q;
    logic [XLEN-1:0] key_rs2_q;
    logic            cache_valid_q;
    logic            cache_div_q;
    logic [1:0]      cache_sgn_q;
    logic [XLEN-1:0] cache_rs1_q;
    logic [XLEN-1:0] cache_rs2_q;
    logic [c_W2-1:0] cache_res_q;
    logic            w_accept;
    logic            w_store;

    assign w_accept    = (state_q == S_IDLE) && start && w_valid && !kill;
    assign w_store     = (state_q == S_FIXUP) && !kill;
    assign w_hit       = cache_valid_q && (cache_div_q == w_is_div)
                         && (cache_sgn_q == {w_a_sgn, w_b_sgn})
                         && (cache_rs1_q == rs1) && (cache_rs2_q == rs2);
    assign w_cache_res = cache_res_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            key_div_q     <= 1'b0;
            key_sgn_q     <= '0;
            key_rs1_q     <= '0;
            key_rs2_q     <= '0;
            cache_valid_q <= 1'b0;
            cache_div_q   <= 1'b0;
            cache_sgn_q   <= '0;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_res_q   <= '0;
        end else begin
            if (w_accept) begin
                key_div_q <= w_is_div;
                key_sgn_q <= {w_a_sgn, w_b_sgn};
                key_rs1_q <= rs1;
                key_rs2_q <= rs2;
            end
            if (w_store) begin
                cache_valid_q <= 1'b1;
                cache_div_q   <= key_div_q;
                cache_sgn_q   <= key_sgn_q;
                cache_rs1_q   <= key_rs1_q;
                cache_rs2_q   <= key_rs2_q;
                cache_res_q   <= w_fix;
            end
        end
    end
`else
    assign w_hit       = 1'b0;
    assign w_cache_res = '0;
`endif

    assign w_cache_rd = w_sel_hi ? w_cache_res[c_W2-1:XLEN] : w_cache_res[XLEN-1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && w_valid) begin
                        div_q    <= w_is_div;
                        sel_hi_q <= w_sel_hi;
                        if (w_special) begin
                            rd_q    <= w_spec_res;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (w_hit) begin
                            rd_q    <= w_cache_rd;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            acc_q   <= w_is_div ? {{XLEN{1'b0}}, w_a_abs} : '0;
                            mcand_q <= {{XLEN{1'b0}}, w_a_abs};
                            b_q     <= w_b_abs;
                            neg_q   <= w_a_neg ^ w_b_neg;
                            rneg_q  <= w_a_neg;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (div_q) begin
                        acc_q <= w_div_step;
                    end else begin
                        acc_q   <= acc_q + w_pp;
                        mcand_q <= mcand_q << MUL_UNROLL;
                        b_q     <= b_q >> MUL_UNROLL;
                    end
                    if (cnt_q == w_last) begin
                        state_q <= S_FIXUP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIXUP: begin
                    rd_q    <= w_fix_rd;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign rd   = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// tb_muldiv_seq: scoreboard bench for muldiv_seq, XLEN=32 with unroll 1 and unroll 4 instances.
module tb_muldiv_seq;

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic        start4;
    logic [4:0]  op;
    logic [4:0]  op4;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs1_4;
    logic [31:0] rs2_4;
    logic        busy;
    logic        done;
    logic        busy4;
    logic        done4;
    logic [31:0] rd;
    logic [31:0] rd4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rd;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] last_rd;
    bit          c_valid;
    logic        c_div;
    logic [1:0]  c_sgn;
    logic [31:0] c_a;
    logic [31:0] c_b;

    always #5 clock = ~clock;

    muldiv_seq #(.XLEN(32), .MUL_UNROLL(1)) u_dut (
        .clock(clock), .reset(reset), .start(start), .kill(kill), .op(op),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .rd(rd)
    );

    muldiv_seq #(.XLEN(32), .MUL_UNROLL(4)) u_dut4 (
        .clock(clock), .reset(reset), .start(start4), .kill(1'b0), .op(op4),
        .rs1(rs1_4), .rs2(rs2_4), .busy(busy4), .done(done4), .rd(rd4)
    );

    function automatic logic [1:0] sgn_key(input logic [4:0] o);
        logic [1:0] k;
        if (o[2]) k = o[0] ? 2'b00 : 2'b11;
        else if (o[1:0] == 2'b10) k = 2'b10;
        else if (o[1:0] == 2'b11) k = 2'b00;
        else k = 2'b11;
        return k;
    endfunction

    function automatic bit is_special(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return (a == 0) || (b == 0);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!o[2]) begin
            case (o[1:0])
                2'b00: p = {32'b0, a} * {32'b0, b};
                2'b01: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                2'b10: p = {{32{a[31]}}, a} * {32'b0, b};
                default: p = {32'b0, a} * {32'b0, b};
            endcase
            return (o[1:0] == 2'b00) ? p[31:0] : p[63:32];
        end
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
            return o[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        end
        return o[1] ? a % b : a / b;
    endfunction

    // intrude > 0 pulses a start (DIVU by zero) on that cycle while the op runs
    task automatic run_op(input bit u4, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int intrude, input string name);
        exp_t e;
        exp_t got;
        int   lat;
        int   busy_cnt;
        bit   hit;
        bit   sp;
        bit   d;
        sp  = is_special(o, a, b);
        hit = !u4 && c_valid && (c_div == o[2]) && (c_sgn == sgn_key(o)) && (c_a == a) && (c_b == b);
`ifndef MULDIV_RESULT_CACHE_EN
        hit = 1'b0;
`endif
        e.rd = ref_result(o, a, b);
        if (sp || hit) begin
            e.lat = 1;
        end else begin
            e.lat = (u4 && !o[2]) ? 10 : 34;
            if (!u4) begin
                c_valid = 1'b1; c_div = o[2]; c_sgn = sgn_key(o); c_a = a; c_b = b;
            end
        end
        sb.push_back(e);
        @(negedge clock);
        if (u4) begin start4 = 1'b1; op4 = o; rs1_4 = a; rs2_4 = b; end
        else begin start = 1'b1; op = o; rs1 = a; rs2 = b; end
        @(negedge clock);
        start = 1'b0; start4 = 1'b0;
        rs1 = $urandom; rs2 = $urandom; rs1_4 = $urandom; rs2_4 = $urandom;
        lat = 1; busy_cnt = 0;
        d = u4 ? done4 : done;
        while (!d && lat < 100) begin
            if (u4 ? busy4 : busy) busy_cnt++;
            if (lat == intrude) begin start = 1'b1; op = OP_DIVU; rs2 = 32'h0; end
            @(negedge clock);
            start = 1'b0;
            lat++;
            d = u4 ? done4 : done;
        end
        got = sb.pop_front();
        n_checks++;
        if (!d) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles (expected at %0d)", name, lat, got.lat);
        end else begin
            n_checks++;
            if ((u4 ? rd4 : rd) !== got.rd) begin
                n_fail++;
                $display("FAIL %s rd: got %h expected %h", name, u4 ? rd4 : rd, got.rd);
            end
            n_checks++;
            if (lat != got.lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, got.lat);
            end
            n_checks++;
            if (busy_cnt != got.lat - 1) begin
                n_fail++;
                $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, got.lat - 1);
            end
            n_checks++;
            if ((u4 ? busy4 : busy) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy at done: got %b expected 0", name, u4 ? busy4 : busy);
            end
        end
        if (!u4) last_rd = got.rd;
    endtask

    task automatic expect_bits(input logic [31:0] got, input logic [31:0] exp, input string name);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic count_no_done(input int cycles, input string name);
        int nd;
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done === 1'b1) nd++;
        end
        n_checks++;
        if (nd != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d done pulses expected 0", name, nd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; kill = 1'b0; start4 = 1'b0;
        op = 5'b0; op4 = 5'b0; rs1 = '0; rs2 = '0; rs1_4 = '0; rs2_4 = '0;
        repeat (3) @(negedge clock);
        expect_bits({31'b0, busy}, 32'h0, "reset_busy");
        expect_bits({31'b0, done}, 32'h0, "reset_done");
        expect_bits(rd, 32'h0, "reset_rd");
        expect_bits({31'b0, busy4}, 32'h0, "reset_busy4");
        expect_bits(rd4, 32'h0, "reset_rd4");
        reset = 1'b1;
        c_valid = 1'b0;
        last_rd = 32'h0;
    endtask

    task automatic test_mul();
        run_op(0, OP_MUL,   32'h0000_1234, 32'h0000_0010, 0, "case1_mul");
        run_op(0, OP_MULH,  32'hFFFF_FFFF, 32'h0000_0002, 0, "case2_mulh");
        run_op(0, OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 0, "case2_mulhu");
        run_op(0, OP_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, "mulhsu_neg");
        run_op(0, OP_MULH,  32'h8000_0000, 32'h8000_0000, 0, "mulh_minmin");
    endtask

    task automatic test_div();
        run_op(0, OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 0, "case3_div");
        run_op(0, OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 0, "case3_rem");
        run_op(0, OP_DIVU, 32'd100, 32'd7, 0, "case3_divu");
        run_op(0, OP_REM,  32'd17, 32'hFFFF_FFFB, 0, "rem_neg_divisor");
    endtask

    task automatic test_special();
        run_op(0, OP_DIVU, 32'd55, 32'h0, 0, "case4_divu_zero");
        run_op(0, OP_REM,  32'h8000_0000, 32'h0, 0, "case4_rem_zero");
        run_op(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, "case4_div_ovf");
        run_op(0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
        run_op(0, OP_MULHU, 32'h0, 32'hDEAD_BEEF, 0, "mul_zero");
    endtask

    task automatic test_random();
        logic [31:0] v[2];
        logic [4:0]  o;
        for (int n = 0; n < 20; n++) begin
            o = OP_MUL | 5'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 5))
                    0: v[k] = 32'h0;
                    1: v[k] = 32'h8000_0000;
                    2: v[k] = 32'hFFFF_FFFF;
                    3: v[k] = 32'($urandom_range(1, 20));
                    default: v[k] = $urandom;
                endcase
            end
            run_op(0, o, v[0], v[1], 0, "random");
        end
    endtask

    task automatic test_kill();
        @(negedge clock); start = 1'b1; op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3;
        @(negedge clock); start = 1'b0;
        repeat (9) @(negedge clock);
        expect_bits({31'b0, busy}, 32'h1, "kill_busy_before");
        kill = 1'b1; start = 1'b1; op = OP_MUL; rs1 = 32'd5; rs2 = 32'd6;
        @(negedge clock); kill = 1'b0; start = 1'b0;
        expect_bits({31'b0, busy}, 32'h0, "kill_busy_after");
        expect_bits({31'b0, done}, 32'h0, "kill_done_after");
        expect_bits(rd, last_rd, "kill_rd_kept");
        count_no_done(40, "kill_no_done");
        @(negedge clock); start = 1'b1; kill = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'h0;
        @(negedge clock); start = 1'b0; kill = 1'b0;
        expect_bits({30'b0, busy, done}, 32'h0, "kill_with_start_idle");
        @(negedge clock); start = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'h0;
        @(negedge clock); start = 1'b0; kill = 1'b1;
        expect_bits({31'b0, done}, 32'h1, "kill_in_done_pulse");
        expect_bits(rd, 32'hFFFF_FFFF, "kill_in_done_rd");
        @(negedge clock); kill = 1'b0;
        expect_bits({30'b0, busy, done}, 32'h0, "kill_in_done_after");
        expect_bits(rd, 32'hFFFF_FFFF, "kill_in_done_rd_kept");
        last_rd = 32'hFFFF_FFFF;
    endtask

    task automatic test_back_to_back();
        run_op(0, OP_MUL, 32'h0000_0123, 32'h0000_0456, 5, "start_while_busy");
        start = 1'b1; op = OP_DIVU; rs1 = 32'd1; rs2 = 32'h0;
        @(negedge clock); start = 1'b0;
        expect_bits({30'b0, busy, done}, 32'h0, "start_in_done_ignored");
        expect_bits(rd, last_rd, "start_in_done_rd");
        run_op(0, OP_REMU, 32'hFFFF_FFFF, 32'd10, 0, "b2b_remu");
        run_op(0, OP_DIVU, 32'hFFFF_FFFF, 32'd10, 0, "b2b_divu");
    endtask

    task automatic test_reset_mid();
        @(negedge clock); start = 1'b1; op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd7;
        @(negedge clock); start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0; start = 1'b1; kill = 1'b1; op = OP_DIVU; rs2 = 32'h0;
        @(negedge clock); reset = 1'b1; start = 1'b0; kill = 1'b0;
        expect_bits({31'b0, busy}, 32'h0, "reset_mid_busy");
        expect_bits({31'b0, done}, 32'h0, "reset_mid_done");
        expect_bits(rd, 32'h0, "reset_mid_rd");
        last_rd = 32'h0;
        c_valid = 1'b0;
        count_no_done(40, "reset_mid_no_done");
    endtask

    task automatic test_cache();
        run_op(0, OP_DIV, 32'd100, 32'd7, 0, "case6_div");
        @(negedge clock); start = 1'b1; op = OP_DIVU; rs1 = 32'd50; rs2 = 32'd3;
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        kill = 1'b1;
        @(negedge clock); kill = 1'b0;
        run_op(0, OP_REM,    32'd100, 32'd7, 0, "case6_rem");
        run_op(0, OP_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 0, "cache_mul");
        run_op(0, OP_MULH,   32'h1234_5678, 32'h9ABC_DEF0, 0, "cache_mulh");
        run_op(0, OP_MULHSU, 32'h1234_5678, 32'h9ABC_DEF0, 0, "cache_mulhsu");
    endtask

    task automatic test_unroll4();
        run_op(1, OP_MUL,    32'h0000_1234, 32'h0000_0010, 0, "u4_mul");
        run_op(1, OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 0, "u4_mulh");
        run_op(1, OP_MULHU,  32'hFFFF_FFFE, 32'h0000_0003, 0, "u4_mulhu");
        run_op(1, OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 0, "u4_mulhsu");
        run_op(1, OP_DIVU,   32'd1000, 32'd9, 0, "u4_divu");
        run_op(1, OP_MUL,    32'h0, 32'd5, 0, "u4_mul_zero");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_kill();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_cache();
        test_unroll4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
